// File: rtl/vga_fb_arbiter_if.sv
// Bundle of the display, CPU and framebuffer-RAM signals around vga_fb_arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters and RAM.
interface vga_fb_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_starve;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_valid, disp_data, cpu_ack, cpu_rdata, cpu_starve,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_valid, disp_data, cpu_ack, cpu_rdata, cpu_starve,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch has absolute priority with fixed
// 2-cycle read latency; CPU req/ack accesses fill idle slots; starvation is flagged.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = 1024
) (
  input logic               clock,
  input logic               reset_n,
  vga_fb_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_DISP   = 2'd1,
    TAG_CPU_RD = 2'd2,
    TAG_CPU_WR = 2'd3
  } tag_e;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_BUSY = 1'b1
  } cstate_e;

  cstate_e           state_q, state_d;
  tag_e              tag1_q, tag1_d;
  tag_e              tag2_q, tag2_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              cpu_starve_q, cpu_starve_d;
  logic              cpu_grant;

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= C_IDLE;
      tag1_q       <= TAG_NONE;
      tag2_q       <= TAG_NONE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      starve_cnt_q <= '0;
      cpu_starve_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_starve_q <= cpu_starve_d;
    end
  end

  // Slot arbitration, owner pipeline, CPU FSM and starve counter
  always_comb begin
    state_d      = state_q;
    tag1_d       = TAG_NONE;
    tag2_d       = tag1_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    disp_valid_d = 1'b0;
    disp_data_d  = disp_data_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    starve_cnt_d = starve_cnt_q;
    cpu_starve_d = cpu_starve_q;

    // The edge on which ack is visible ignores cpu_req so a held request is not re-issued
    cpu_grant = !bus.disp_req && (state_q == C_IDLE) && bus.cpu_req && !cpu_ack_q;

    if (bus.disp_req) begin
      mem_addr_d = bus.disp_addr;
      tag1_d     = TAG_DISP;
    end else if (cpu_grant) begin
      mem_addr_d  = bus.cpu_addr;
      mem_we_d    = bus.cpu_we;
      mem_wdata_d = bus.cpu_wdata;
      tag1_d      = bus.cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      state_d     = C_BUSY;
    end

    // Stage-2 tag names the owner of the RAM data arriving this cycle
    case (tag2_q)
      TAG_DISP: begin
        disp_data_d  = bus.mem_rdata;
        disp_valid_d = 1'b1;
      end
      TAG_CPU_RD: begin
        cpu_rdata_d = bus.mem_rdata;
        cpu_ack_d   = 1'b1;
        state_d     = C_IDLE;
      end
      TAG_CPU_WR: begin
        cpu_ack_d = 1'b1;
        state_d   = C_IDLE;
      end
      default: ;
    endcase

    if (cpu_grant) begin
      starve_cnt_d = '0;
    end else if (bus.cpu_req && (state_q == C_IDLE) &&
                 (starve_cnt_q < CNT_W'(STARVE_MAX))) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    cpu_starve_d = (starve_cnt_d >= CNT_W'(STARVE_MAX));
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_starve = cpu_starve_q;

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port framebuffer RAM between two requesters:
  - the VGA pixel fetch path, which has hard real-time priority;
  - a CPU/host port, which uses a req/ack handshake.
- Sits between the 25 MHz-domain timing/pixel generator and the framebuffer RAM.
- Guarantees fixed-latency pixel reads and serves CPU accesses in idle memory slots.
- Flags CPU starvation for debug.

Parameters:
- ADDR_W, 16, framebuffer address width.
- DATA_W, 8, pixel/data width; matches the 8-bit colour output.
- STARVE_MAX, 1024, pending-cycle count at which cpu_starve asserts.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- disp_req  in  1  display read request; single-cycle per pixel; may be high every cycle.
- disp_addr  in  ADDR_W  pixel address, sampled with disp_req.
- disp_valid  out  1  one-cycle pulse: disp_data is valid.
- disp_data  out  DATA_W  pixel read data.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1 for reads.
- cpu_starve  out  1  CPU pending >= STARVE_MAX cycles.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data; valid one cycle after address (synchronous RAM).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all outputs 0, including mem_addr, mem_wdata, disp_data and cpu_rdata;
  - owner pipeline cleared, CPU FSM to C_IDLE, starve counter 0.
- Reset mid-operation drops in-flight accesses: no disp_valid or cpu_ack is produced for them.
- Slot arbitration, one memory access per cycle, decided at each posedge:
  - disp_req=1: display wins unconditionally. mem_addr<=disp_addr, mem_we<=0, tag DISP.
  - else, if CPU FSM is C_IDLE, cpu_req=1 and cpu_ack=0: CPU wins. mem_addr<=cpu_addr, mem_we<=cpu_we, mem_wdata<=cpu_wdata, tag CPU(rd/wr).
  - else: idle slot. mem_we<=0, mem_addr holds its value, tag NONE.
- Owner pipeline: a 2-stage tag shift register tracks in-flight slots.
  - Request sampled at edge N; RAM sees the address at edge N+1.
  - At edge N+2, mem_rdata is captured according to the stage-2 tag:
    - DISP: disp_data<=mem_rdata, disp_valid<=1.
    - CPU read: cpu_rdata<=mem_rdata, cpu_ack<=1.
    - CPU write: cpu_ack<=1; cpu_rdata unchanged.
  - Fixed latency is exactly 2 cycles from request edge to valid, for both ports.
  - disp_valid and cpu_ack are 1 for exactly one cycle per access.
  - disp_data is not modified on non-DISP slots.
- CPU FSM:
  - C_IDLE -> C_BUSY on CPU grant.
  - C_BUSY -> C_IDLE at the edge where cpu_ack is set.
  - At the following edge (cpu_ack=1), cpu_req is ignored. This lets the requester drop req or present a new request without double issue.
  - Minimum CPU access period is 4 cycles.
- Back-to-back display requests every cycle are supported. Each returns in order with 2-cycle latency, with no bubbles.
- Simultaneous disp_req and cpu_req: display wins; CPU stays pending with its inputs held.
- Starve counter:
  - increments on each edge where cpu_req=1, FSM=C_IDLE and the CPU is not granted;
  - saturates at STARVE_MAX and clears on CPU grant;
  - cpu_starve = (count >= STARVE_MAX), registered.
- Address/data widths pass straight through; no arithmetic.

Test Plan:
- Reset: hold reset_n=0 with random inputs -> all outputs 0. Assert reset_n=0 mid-CPU-read -> no cpu_ack follows.
- Display stream: disp_req=1 for 8 cycles, addr 0x0000..0x0007, RAM preloaded with data=addr -> disp_valid high 8 consecutive cycles starting 2 edges later, data 0x00..0x07 in order.
- CPU write then read: write 0x1234<=0xA5 with no display traffic -> cpu_ack 2 edges after grant, mem_we high exactly 1 cycle. Then read 0x1234 -> cpu_rdata=0xA5 with cpu_ack.
- Collision: cpu_req (read 0x0010) and disp_req (0x0020) on the same edge -> display is served first. CPU is granted the first cycle disp_req=0, and cpu_ack fires exactly 2 edges after that.
- Hold-over: requester keeps cpu_req high across the ack with a new address -> exactly one ack per request, second grant no earlier than 4 cycles after the first.
- Starvation: STARVE_MAX=16, disp_req=1 continuously, cpu_req=1 -> cpu_starve rises after 16 pending edges. Drop disp_req -> CPU granted, cpu_starve falls next cycle.
